// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
// Op codes follow the execute-stage decode; states drive the FSM.
package mult_div_unit_pkg;

  localparam int N_BITS   = 32;
  localparam int CNT_BITS = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between execute stage and the mult/div unit.
// master = issuing pipeline, slave = mult/div unit.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic              start_i;
  logic [2:0]        op_i;
  logic              abort_i;
  logic [N_BITS-1:0] rs_data_i;
  logic [N_BITS-1:0] rt_data_i;
  logic [N_BITS-1:0] hi_o;
  logic [N_BITS-1:0] lo_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, op_i, abort_i,
    output rs_data_i, rt_data_i,
    input  hi_o, lo_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, abort_i,
    input  rs_data_i, rt_data_i,
    output hi_o, lo_o, busy_o, done_o
  );

endinterface

// File: rtl/mult_div_unit_twos_magnitude.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and result sign fix-up.
module mult_div_unit_twos_magnitude #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  // Negate when requested; the most negative value maps to itself.
  always_comb begin
    o_val = i_neg ? (~i_val + 1'b1) : i_val;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Fixed 33-cycle latency: 32 shift iterations plus a sign fix-up.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  state_e r_state;
  state_e w_next;

  logic [CNT_BITS-1:0] r_cnt;
  logic [2*N_BITS-1:0] r_acc;
  logic [N_BITS-1:0]   r_dvs;
  logic [N_BITS-1:0]   r_rem;
  logic [N_BITS-1:0]   r_rs_raw;
  logic [N_BITS-1:0]   r_hi;
  logic [N_BITS-1:0]   r_lo;
  logic                r_div;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_dz;
  logic                r_done;

  logic                w_accept;
  logic                w_md;
  logic                w_signed;
  logic                w_fix_wr;
  logic [N_BITS-1:0]   w_rs_mag;
  logic [N_BITS-1:0]   w_rt_mag;
  logic [N_BITS-1:0]   w_addend;
  logic [N_BITS:0]     w_sum;
  logic [N_BITS-1:0]   w_shift;
  logic                w_ge;
  logic [N_BITS-1:0]   w_rem_nxt;
  logic [2*N_BITS-1:0] w_prod_fix;
  logic [N_BITS-1:0]   w_quo_fix;
  logic [N_BITS-1:0]   w_rem_fix;

  assign w_accept = (r_state == S_IDLE)
                  & bus.start_i & ~bus.abort_i;
  assign w_md     = w_accept & ~bus.op_i[2];
  assign w_signed = (bus.op_i == OP_MULT)
                  | (bus.op_i == OP_DIV);
  assign w_fix_wr = (r_state == S_FIX) & ~bus.abort_i;

  mult_div_unit_twos_magnitude #(.W(N_BITS)) u_rs_mag (
    .i_neg (w_signed & bus.rs_data_i[N_BITS-1]),
    .i_val (bus.rs_data_i),
    .o_val (w_rs_mag)
  );

  mult_div_unit_twos_magnitude #(.W(N_BITS)) u_rt_mag (
    .i_neg (w_signed & bus.rt_data_i[N_BITS-1]),
    .i_val (bus.rt_data_i),
    .o_val (w_rt_mag)
  );

  mult_div_unit_twos_magnitude #(.W(2*N_BITS)) u_prod_fix (
    .i_neg (r_neg_res),
    .i_val (r_acc),
    .o_val (w_prod_fix)
  );

  mult_div_unit_twos_magnitude #(.W(N_BITS)) u_quo_fix (
    .i_neg (r_neg_res),
    .i_val (r_acc[N_BITS-1:0]),
    .o_val (w_quo_fix)
  );

  mult_div_unit_twos_magnitude #(.W(N_BITS)) u_rem_fix (
    .i_neg (r_neg_rem),
    .i_val (r_rem),
    .o_val (w_rem_fix)
  );

  // One shift-add (mult) or restoring shift-subtract (div) step.
  always_comb begin
    w_addend  = r_acc[0] ? r_dvs : '0;
    w_sum     = {1'b0, r_acc[2*N_BITS-1:N_BITS]}
              + {1'b0, w_addend};
    w_shift   = {r_rem[N_BITS-2:0], r_acc[N_BITS-1]};
    w_ge      = r_rem[N_BITS-1] | (w_shift >= r_dvs);
    w_rem_nxt = w_ge ? (w_shift - r_dvs) : w_shift;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: abort returns to IDLE from RUN or FIX.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_md) w_next = S_RUN;
      S_RUN: begin
        if (bus.abort_i)
          w_next = S_IDLE;
        else if (r_cnt == CNT_BITS'(N_BITS - 1))
          w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture on issue, then iterate while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_rs_raw  <= '0;
      r_div     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
    end else if (w_md) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_rs_raw  <= bus.rs_data_i;
      r_div     <= bus.op_i[1];
      r_neg_res <= w_signed & (bus.rs_data_i[N_BITS-1]
                             ^ bus.rt_data_i[N_BITS-1]);
      r_neg_rem <= w_signed & bus.rs_data_i[N_BITS-1];
      r_dz      <= (bus.rt_data_i == '0);
      if (bus.op_i[1]) begin
        r_acc <= {{N_BITS{1'b0}}, w_rs_mag};
        r_dvs <= w_rt_mag;
      end else begin
        r_acc <= {{N_BITS{1'b0}}, w_rt_mag};
        r_dvs <= w_rs_mag;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_div) begin
        r_rem <= w_rem_nxt;
        r_acc <= {r_acc[2*N_BITS-1:N_BITS],
                  r_acc[N_BITS-2:0], w_ge};
      end else begin
        r_acc <= {w_sum, r_acc[N_BITS-1:1]};
      end
    end
  end

  // HI/LO: moves in IDLE, sign-fixed results in FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix_wr;
      if (w_accept && bus.op_i == OP_MTHI)
        r_hi <= bus.rs_data_i;
      if (w_accept && bus.op_i == OP_MTLO)
        r_lo <= bus.rs_data_i;
      if (w_fix_wr) begin
        if (!r_div) begin
          r_hi <= w_prod_fix[2*N_BITS-1:N_BITS];
          r_lo <= w_prod_fix[N_BITS-1:0];
        end else if (r_dz) begin
          r_hi <= r_rs_raw;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end
    end
  end

  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;
  assign bus.busy_o = (r_state != S_IDLE);
  assign bus.done_o = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit.
// Table of mult/div results plus hand-written corner sequences.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk;
  logic rst_n;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t v[13];
  int   n_pass;
  int   n_tot;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Present an op for one edge; returns at sample 0 (edge+1).
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = a;
    bus.rt_data_i = b;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
  endtask

  // Count busy/done over n samples, first one without advancing.
  task automatic watch(input int n, output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      bc += int'(bus.busy_o);
      dc += int'(bus.done_o);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Abort a MULT at sample k; HI/LO must hold hi0/lo0.
  task automatic run_abort(input int k,
                           input logic [31:0] hi0,
                           input logic [31:0] lo0);
    int bc, dc;
    issue(3'(OP_MULT), 32'd3, 32'd3);
    step(k);
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    chk($sformatf("abort%0d_busy", k), 32'(bus.busy_o), 0);
    watch(40, bc, dc);
    chk($sformatf("abort%0d_done", k), dc, 0);
    chk($sformatf("abort%0d_hi", k), bus.hi_o, hi0);
    chk($sformatf("abort%0d_lo", k), bus.lo_o, lo0);
  endtask

  initial begin
    int bc, dc;
    logic [31:0] prev_lo;
    n_pass = 0;
    n_tot  = 0;

    v[0]  = '{"mult_m3x7",  3'(OP_MULT),  32'hFFFF_FFFD, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[1]  = '{"multu_max",  3'(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001};
    v[2]  = '{"divu_100_7", 3'(OP_DIVU),  32'd100, 32'd7,
              32'd2, 32'd14};
    v[3]  = '{"div_m7_2",   3'(OP_DIV),   32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[4]  = '{"div_min_m1", 3'(OP_DIV),   32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000};
    v[5]  = '{"div_5_0",    3'(OP_DIV),   32'd5, 32'd0,
              32'd5, 32'hFFFF_FFFF};
    v[6]  = '{"div_m5_0",   3'(OP_DIV),   32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF};
    v[7]  = '{"divu_max_0", 3'(OP_DIVU),  32'hFFFF_FFFF, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[8]  = '{"div_7_m2",   3'(OP_DIV),   32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD};
    v[9]  = '{"mult_min2",  3'(OP_MULT),  32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0};
    v[10] = '{"multu_sh4",  3'(OP_MULTU), 32'h1234_5678, 32'h10,
              32'h1, 32'h2345_6780};
    v[11] = '{"divu_min_m", 3'(OP_DIVU),  32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 32'h0};
    v[12] = '{"mult_5_m1",  3'(OP_MULT),  32'd5, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'hFFFF_FFFB};

    bus.start_i   = 1'b0;
    bus.op_i      = 3'd0;
    bus.abort_i   = 1'b0;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;
    rst_n = 1'b0;
    step(3);
    chk("rst_hi",   bus.hi_o, 0);
    chk("rst_lo",   bus.lo_o, 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 13; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      watch(36, bc, dc);
      chk({v[i].nm, "_busy"}, bc, 33);
      chk({v[i].nm, "_done"}, dc, 1);
      chk({v[i].nm, "_hi"}, bus.hi_o, v[i].hi);
      chk({v[i].nm, "_lo"}, bus.lo_o, v[i].lo);
    end

    // MTHI then MTLO back to back.
    prev_lo = v[12].lo;
    bus.start_i   = 1'b1;
    bus.op_i      = 3'(OP_MTHI);
    bus.rs_data_i = 32'h1234;
    @(posedge clk); #1;
    chk("mthi_hi", bus.hi_o, 32'h1234);
    chk("mthi_lo_held", bus.lo_o, prev_lo);
    chk("mthi_busy", 32'(bus.busy_o), 0);
    bus.op_i      = 3'(OP_MTLO);
    bus.rs_data_i = 32'hABCD;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    chk("mtlo_lo", bus.lo_o, 32'hABCD);
    chk("mtlo_hi", bus.hi_o, 32'h1234);
    chk("mtlo_busy", 32'(bus.busy_o), 0);
    chk("mtlo_done", 32'(bus.done_o), 0);

    // Start while busy is ignored.
    issue(3'(OP_MULTU), 32'd3, 32'd4);
    step(5);
    issue(3'(OP_MTLO), 32'h55, 32'd0);
    watch(30, bc, dc);
    chk("busy_ign_done", dc, 1);
    chk("busy_ign_lo", bus.lo_o, 32'd12);
    chk("busy_ign_hi", bus.hi_o, 32'd0);

    // Preload HI/LO, then abort in RUN and in FIX.
    issue(3'(OP_MTHI), 32'hAAAA, 32'd0);
    issue(3'(OP_MTLO), 32'hBBBB, 32'd0);
    run_abort(10, 32'hAAAA, 32'hBBBB);
    run_abort(32, 32'hAAAA, 32'hBBBB);

    // Abort with start in IDLE: nothing accepted.
    bus.abort_i = 1'b1;
    issue(3'(OP_MTHI), 32'h77, 32'd0);
    chk("abort_idle_hi", bus.hi_o, 32'hAAAA);
    chk("abort_idle_busy", 32'(bus.busy_o), 0);
    bus.abort_i = 1'b0;
    issue(3'(OP_DIVU), 32'd8, 32'd2);
    chk("abort_idle_mult_busy", 32'(bus.busy_o), 1);
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;

    // Asynchronous reset mid-DIV.
    issue(3'(OP_DIV), 32'd100, 32'd7);
    step(19);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hi", bus.hi_o, 0);
    chk("arst_lo", bus.lo_o, 0);
    chk("arst_busy", 32'(bus.busy_o), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    issue(3'(OP_DIVU), 32'd9, 32'd3);
    watch(36, bc, dc);
    chk("post_rst_busy", bc, 33);
    chk("post_rst_done", dc, 1);
    chk("post_rst_lo", bus.lo_o, 32'd3);
    chk("post_rst_hi", bus.hi_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
